// File: rtl/tap_fir_engine_if.sv
// Handshake bundle between the tap generator / sample source and tap_fir_engine.
// master drives taps and samples; slave is the FIR engine.
interface tap_fir_engine_if #(
   parameter int DW = 16,
   parameter int CW = 16
);
   logic          tap_valid;
   logic [7:0]    tapnum;
   logic [CW-1:0] tapcoeff;
   logic          tap_last;
   logic          coef_ready;
   logic          sample_valid;
   logic [DW-1:0] sample_in;
   logic          sample_ready;
   logic          out_valid;
   logic [DW-1:0] out_sample;
   logic          busy;

   modport master (
      output tap_valid, tapnum, tapcoeff, tap_last,
      input  coef_ready,
      output sample_valid, sample_in,
      input  sample_ready, out_valid, out_sample, busy
   );

   modport slave (
      input  tap_valid, tapnum, tapcoeff, tap_last,
      output coef_ready,
      input  sample_valid, sample_in,
      output sample_ready, out_valid, out_sample, busy
   );
endinterface

// File: rtl/tap_fir_engine.sv
// Sequential-MAC FIR fed by a tapnum/tapcoeff stream; one multiply per cycle.
// Optional TAP_SHADOW_EN: taps land in a shadow bank, copied to the active bank in IDLE.
module tap_fir_engine #(
   parameter int NTAPS = 16,
   parameter int DW    = 16,
   parameter int CW    = 16,
   parameter int AW    = 40
) (
   input  logic            clk,
   input  logic            reset,
   tap_fir_engine_if.slave fir_io
);
   localparam int KW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
   localparam int PW = DW + CW;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MAC  = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   logic [1:0]                state_q, state_d;
   logic [KW-1:0]             k_q, k_d;
   logic signed [AW-1:0]      acc_q, acc_d;
   logic [NTAPS-1:0][DW-1:0]  x_q, x_d;
   logic [NTAPS-1:0][CW-1:0]  coef_q;
   logic                      loaded_q;
   logic                      rst_hold_q;
   logic                      out_valid_q;
   logic [DW-1:0]             out_sample_q;

   logic                      idle, in_mac, last_k;
   logic                      coef_rdy, tap_fire, tap_in_range;
   logic                      smp_rdy, smp_fire;
   logic [KW-1:0]             tap_idx;
   logic signed [PW-1:0]      prod;
   logic signed [AW-1:0]      prod_ext;
   logic signed [AW-1:0]      acc_sh;
   logic [AW-DW:0]            sat_hi;
   logic                      sat_ovf;
   logic [DW-1:0]             sat_val;

   assign idle   = (state_q == S_IDLE);
   assign in_mac = (state_q == S_MAC);
   assign last_k = (k_q == KW'(NTAPS-1));

   assign tap_idx      = fir_io.tapnum[KW-1:0];
   assign tap_in_range = (int'(fir_io.tapnum) < NTAPS);

`ifdef TAP_SHADOW_EN
   logic [NTAPS-1:0][CW-1:0] shadow_q;
   logic                     pend_q;
   logic                     copy_go;

   // The copy cycle blocks sample accept so a sample never sees a half-updated bank.
   assign copy_go  = idle & pend_q;
   assign coef_rdy = ~rst_hold_q;
   assign tap_fire = fir_io.tap_valid & coef_rdy;
   assign smp_rdy  = idle & loaded_q & ~pend_q & ~tap_fire;

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q <= '0;
         pend_q   <= 1'b0;
         coef_q   <= '0;
      end else begin
         if (copy_go)
            coef_q <= shadow_q;
         if (tap_fire && tap_in_range)
            shadow_q[tap_idx] <= fir_io.tapcoeff;
         if (tap_fire && fir_io.tap_last)
            pend_q <= 1'b1;
         else if (copy_go)
            pend_q <= 1'b0;
      end
   end
`else
   assign coef_rdy = idle & ~rst_hold_q;
   assign tap_fire = fir_io.tap_valid & coef_rdy;
   assign smp_rdy  = idle & loaded_q & ~tap_fire;

   always_ff @(posedge clk) begin
      if (reset)
         coef_q <= '0;
      else if (tap_fire && tap_in_range)
         coef_q[tap_idx] <= fir_io.tapcoeff;
   end
`endif

   assign smp_fire = fir_io.sample_valid & smp_rdy;

   // Full-precision signed product, sign-extended into the accumulator.
   assign prod     = $signed(coef_q[k_q]) * $signed(x_q[k_q]);
   assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      acc_d   = acc_q;
      x_d     = x_q;
      case (state_q)
         S_IDLE: begin
            if (smp_fire) begin
               x_d     = {x_q[NTAPS-2:0], fir_io.sample_in};
               acc_d   = '0;
               k_d     = '0;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            acc_d = acc_q + prod_ext;
            k_d   = k_q + KW'(1);
            if (last_k)
               state_d = S_OUT;
         end
         S_OUT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Rescale from Q1.(CW-1) and clamp; evaluated on the final MAC sum so the
   // registered result lines up with the OUT cycle.
   assign acc_sh  = acc_d >>> (CW-1);
   assign sat_hi  = acc_sh[AW-1:DW-1];
   assign sat_ovf = ~((&sat_hi) | (~|sat_hi));
   assign sat_val = sat_ovf ? (acc_sh[AW-1] ? {1'b1, {(DW-1){1'b0}}}
                                            : {1'b0, {(DW-1){1'b1}}})
                            : acc_sh[DW-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         k_q          <= '0;
         acc_q        <= '0;
         x_q          <= '0;
         loaded_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         out_sample_q <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         acc_q       <= acc_d;
         x_q         <= x_d;
         out_valid_q <= in_mac & last_k;
         if (in_mac && last_k)
            out_sample_q <= sat_val;
         if (tap_fire && fir_io.tap_last)
            loaded_q <= 1'b1;
      end
   end

   // Keeps coef_ready low in the cycle following a sampled reset.
   always_ff @(posedge clk) begin
      rst_hold_q <= reset;
   end

   assign fir_io.coef_ready   = coef_rdy;
   assign fir_io.sample_ready = smp_rdy;
   assign fir_io.out_valid    = out_valid_q;
   assign fir_io.out_sample   = out_sample_q;
   assign fir_io.busy         = (state_q == S_MAC) | (state_q == S_OUT);

endmodule

// File: tb/tb_tap_fir_engine.sv
// Self-checking bench for tap_fir_engine: directed literal cases plus a random
// stream compared every cycle against a cycle-countdown behavioural model.
module tb_tap_fir_engine;
   localparam int NTAPS = 16;
   localparam int DW    = 16;
   localparam int CW    = 16;
   localparam int AW    = 40;

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   acc_cyc = 0;

   tap_fir_engine_if #(.DW(DW), .CW(CW)) ifc();

   tap_fir_engine #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .AW(AW)) dut (
      .clk    (clk),
      .reset  (reset),
      .fir_io (ifc.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_coef [NTAPS];
   int          m_sh   [NTAPS];
   int          m_x    [NTAPS];
   bit          m_loaded, m_pend;
   bit          last_rst = 1'b1;
   int          rem;
   logic [15:0] m_res, m_hold;
   bit          e_cr, e_sr, e_ov, e_busy, m_idle;

   function automatic logic [15:0] fir_out();
      longint s = 0;
      for (int k = 0; k < NTAPS; k++) s += longint'(m_coef[k]) * longint'(m_x[k]);
      s = s >>> (CW-1);
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      return 16'(s);
   endfunction

   always @(negedge clk) begin
      if (last_rst) begin
         for (int k = 0; k < NTAPS; k++) begin
            m_coef[k] = 0; m_sh[k] = 0; m_x[k] = 0;
         end
         m_loaded = 0; m_pend = 0; rem = 0; m_hold = '0; m_res = '0;
      end
      e_busy = (rem > 0);
      e_ov   = (rem == 1);
      if (e_ov) m_hold = m_res;
`ifdef TAP_SHADOW_EN
      e_cr = !last_rst;
      e_sr = (rem == 0) && m_loaded && !m_pend && !(ifc.tap_valid && e_cr);
`else
      e_cr = !last_rst && (rem == 0);
      e_sr = (rem == 0) && m_loaded && !(ifc.tap_valid && e_cr);
`endif
      chk("busy",         ifc.busy,         e_busy);
      chk("out_valid",    ifc.out_valid,    e_ov);
      chk("out_sample",   ifc.out_sample,   m_hold);
      chk("coef_ready",   ifc.coef_ready,   e_cr);
      chk("sample_ready", ifc.sample_ready, e_sr);

      if (reset) begin
         last_rst = 1'b1;
      end else begin
         last_rst = 1'b0;
         m_idle = (rem == 0);
         if (rem > 0) rem--;
`ifdef TAP_SHADOW_EN
         if (m_idle && m_pend) begin
            for (int k = 0; k < NTAPS; k++) m_coef[k] = m_sh[k];
            m_pend = 0;
         end
`endif
         if (ifc.tap_valid && e_cr) begin
            if (ifc.tapnum < NTAPS) begin
`ifdef TAP_SHADOW_EN
               m_sh[ifc.tapnum] = int'($signed(ifc.tapcoeff));
`else
               m_coef[ifc.tapnum] = int'($signed(ifc.tapcoeff));
`endif
            end
            if (ifc.tap_last) begin
               m_loaded = 1;
`ifdef TAP_SHADOW_EN
               m_pend = 1;
`endif
            end
         end
         if (ifc.sample_valid && e_sr) begin
            for (int k = NTAPS-1; k > 0; k--) m_x[k] = m_x[k-1];
            m_x[0] = int'($signed(ifc.sample_in));
            m_res  = fir_out();
            rem    = NTAPS + 1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      ifc.tap_valid = 0; ifc.tap_last = 0; ifc.sample_valid = 0;
      reset = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;
   endtask

   task automatic write_tap(input int n, input logic [15:0] c, input bit last);
      int t = 0;
      ifc.tap_valid = 1; ifc.tapnum = 8'(n); ifc.tapcoeff = c; ifc.tap_last = last;
      @(negedge clk);
      while (!ifc.coef_ready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) chk("tap_wait_timeout", 32'(t), 0);
      @(posedge clk); #1;
      ifc.tap_valid = 0; ifc.tap_last = 0;
   endtask

   task automatic load_two(input logic [15:0] c0, input logic [15:0] c1);
      for (int i = 0; i < NTAPS; i++)
         write_tap(i, (i == 0) ? c0 : (i == 1) ? c1 : 16'h0000, i == NTAPS-1);
   endtask

   task automatic accept_sample(input logic [15:0] v);
      int t = 0;
      ifc.sample_valid = 1; ifc.sample_in = v;
      @(negedge clk);
      while (!ifc.sample_ready && t < 100) begin @(negedge clk); t++; end
      chk("accept_wait", 32'(t < 100), 1);
      @(posedge clk); #1;
      ifc.sample_valid = 0;
      acc_cyc = cyc;
   endtask

   task automatic expect_out(input string nm, input logic [15:0] lit);
      int t = 0;
      @(negedge clk);
      while (!ifc.out_valid && t < NTAPS + 40) begin @(negedge clk); t++; end
      chk({nm, "_latency"}, 32'(cyc - acc_cyc), NTAPS);
      chk(nm, ifc.out_sample, lit);
      @(posedge clk); #1;
   endtask

   task automatic idle_window(input string nm);
      int nsr = 0, nov = 0;
      ifc.sample_valid = 1; ifc.sample_in = 16'h1111;
      repeat (20) begin
         @(negedge clk);
         nsr += int'(ifc.sample_ready);
         nov += int'(ifc.out_valid);
      end
      chk({nm, "_no_ready"}, 32'(nsr), 0);
      chk({nm, "_no_out"},   32'(nov), 0);
      @(posedge clk); #1;
      ifc.sample_valid = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c;
      reset = 1;
      ifc.tap_valid = 0; ifc.tapnum = '0; ifc.tapcoeff = '0; ifc.tap_last = 0;
      ifc.sample_valid = 1; ifc.sample_in = 16'h1000;
      @(negedge clk);
      chk("rst_coef_ready", ifc.coef_ready, 0);
      chk("rst_busy",       ifc.busy,       0);
      chk("rst_out_valid",  ifc.out_valid,  0);
      chk("rst_out_sample", ifc.out_sample, 0);
      @(posedge clk); #1 reset = 0;

      // no taps loaded: samples never accepted
      idle_window("t1");

      do_reset();
      load_two(16'h4000, 16'h0000);
      accept_sample(16'h1000);
      expect_out("t2_single_tap", 16'h0800);

      // out-of-range tap indices are discarded
      write_tap(20, 16'h1234, 0);
      write_tap(17, 16'h1234, 1);
      accept_sample(16'h0400);
      expect_out("t5_oob_tap", 16'h0200);

      do_reset();
      load_two(16'h0000, 16'h4000);
      accept_sample(16'h2000);
      expect_out("t3_delay_a", 16'h0000);
      accept_sample(16'h0000);
      expect_out("t3_delay_b", 16'h1000);

      do_reset();
      load_two(16'h7FFF, 16'h7FFF);
      accept_sample(16'h7FFF);
      expect_out("t4_pos_a", 16'h7FFE);
      accept_sample(16'h7FFF);
      expect_out("t4_pos_clamp", 16'h7FFF);

      do_reset();
      load_two(16'h7FFF, 16'h7FFF);
      accept_sample(16'h8000);
      expect_out("t4_neg_a", 16'h8001);
      accept_sample(16'h8000);
      expect_out("t4_neg_clamp", 16'h8000);

`ifdef TAP_SHADOW_EN
      // new set written mid-MAC must not affect the in-flight sample
      do_reset();
      load_two(16'h4000, 16'h0000);
      accept_sample(16'h1000);
      write_tap(0, 16'h7FFF, 0);
      write_tap(1, 16'h0000, 1);
      expect_out("t5_shadow_old", 16'h0800);
      accept_sample(16'h1000);
      expect_out("t5_shadow_new", 16'h0FFF);
`endif

      // reset during MAC cycle 5 aborts the sample
      do_reset();
      load_two(16'h4000, 16'h0000);
      accept_sample(16'h1000);
      expect_out("t6_pre", 16'h0800);
      accept_sample(16'h1000);
      repeat (5) @(posedge clk);
      #1 reset = 1;
      @(posedge clk);
      @(negedge clk);
      chk("t6_out_valid",  ifc.out_valid,  0);
      chk("t6_busy",       ifc.busy,       0);
      chk("t6_out_sample", ifc.out_sample, 0);
      @(posedge clk); #1 reset = 0;
      idle_window("t6");
      load_two(16'h4000, 16'h0000);
      accept_sample(16'h2000);
      expect_out("t6_reload", 16'h1000);

      // random stream, checked cycle by cycle by the model
      do_reset();
      repeat (4000) begin
         @(posedge clk); #1;
         reset            = ($urandom_range(0, 599) == 0);
         ifc.tap_valid    = ($urandom_range(0, 5) == 0);
         ifc.tapnum       = 8'($urandom_range(0, 19));
         c                = int'($urandom_range(0, 65535)) - 32768;
         c                = c >>> $urandom_range(0, 5);
         ifc.tapcoeff     = 16'(c);
         ifc.tap_last     = ($urandom_range(0, 3) == 0);
         ifc.sample_valid = $urandom_range(0, 1);
         ifc.sample_in    = 16'($urandom_range(0, 65535));
      end
      @(posedge clk); #1;
      reset = 0; ifc.tap_valid = 0; ifc.sample_valid = 0; ifc.tap_last = 0;
      repeat (NTAPS + 4) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
